// File: rtl/idft_stream_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idft_stream_pkg
// Description : Shared constants, bank-select and capture-state types for
//               the IDFT output streaming block.
// Revision    : 1.0 - initial release
// ============================================================================
package idft_stream_pkg;

    // Default frame geometry: 32 words of four packed 16-bit samples.
    localparam int WORDS = 32;
    localparam int DW    = 64;

    // Index width for a frame of n words; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(WORDS);

    // Selects one of the two ping-pong frame banks.
    typedef enum logic [0:0] {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_t;

    // Capture sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } cap_state_t;

    // The bank opposite to b.
    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage : idft_stream_pkg
`default_nettype wire

// File: rtl/idft_stream_out_if.sv
`default_nettype none
// ============================================================================
// Module      : idft_stream_out_if
// Description : Capture-side and stream-side signals of the IDFT output
//               streamer. The master modport is the streamer itself, the
//               slave modport is the environment (IDFT core + consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface idft_stream_out_if #(
    parameter int DW = idft_stream_pkg::DW
) ();

    logic          next_out;   // frame-start strobe from the IDFT core
    logic [DW-1:0] y_in;       // IDFT output word
    logic          m_valid;    // stream word available
    logic [DW-1:0] m_data;     // stream word
    logic          m_last;     // final word of a frame
    logic          m_ready;    // downstream accept
    logic          overflow;   // sticky frame-drop flag
    logic          clr_ovf;    // clears overflow
    logic          busy;       // capture running or any bank full

    modport master (
        input  next_out, y_in, m_ready, clr_ovf,
        output m_valid, m_data, m_last, overflow, busy
    );

    modport slave (
        output next_out, y_in, m_ready, clr_ovf,
        input  m_valid, m_data, m_last, overflow, busy
    );

endinterface : idft_stream_out_if
`default_nettype wire

// File: rtl/idft_frame_bank.sv
`default_nettype none
// ============================================================================
// Module      : idft_frame_bank
// Description : One frame of storage, WORDS x DW, with a synchronous write
//               port and an asynchronous (combinational) read port.
// Revision    : 1.0 - initial release
// ============================================================================
module idft_frame_bank #(
    parameter  int WORDS = idft_stream_pkg::WORDS,
    parameter  int DW    = idft_stream_pkg::DW,
    localparam int IW    = idft_stream_pkg::idx_width(WORDS)
) (
    input  wire logic          clk_i,
    input  wire logic          we_i,
    input  wire logic [IW-1:0] waddr_i,
    input  wire logic [DW-1:0] wdata_i,
    input  wire logic [IW-1:0] raddr_i,
    output logic      [DW-1:0] rdata_o
);

    // Contents are qualified by the owner's full flag, so no reset is needed.
    logic [DW-1:0] mem_q [WORDS];

    // Write one word per enabled cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : idft_frame_bank
`default_nettype wire

// File: rtl/idft_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : idft_stream_out
// Description : Captures IDFT output frames into two ping-pong banks after
//               each next_out rising edge and replays them as a valid/ready
//               stream with an end-of-frame marker. Frames arriving with no
//               free bank are dropped and flagged through a sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module idft_stream_out #(
    parameter int WORDS = idft_stream_pkg::WORDS,
    parameter int DW    = idft_stream_pkg::DW
) (
    input  wire logic         wb_clk_i,
    input  wire logic         wb_rst_i,
    idft_stream_out_if.master bus
);

    import idft_stream_pkg::*;

    localparam int            IW       = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cap_state_t    state_q,   state_d;
    logic [IW-1:0] wr_idx_q,  wr_idx_d;
    bank_sel_t     wr_bank_q, wr_bank_d;
    logic [IW-1:0] rd_idx_q,  rd_idx_d;
    bank_sel_t     rd_bank_q, rd_bank_d;
    logic [1:0]    full_q,    full_d;
    logic          ovf_q,     ovf_d;
    logic          prev_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          edge_w;        // new rising edge on next_out
    logic          rd_fire_w;     // stream handshake this cycle
    logic          rd_last_w;     // handshake on the final word
    logic          target_free_w; // capture bank usable this cycle
    logic          drop_w;        // frame rejected this cycle
    logic          cap_we_w;      // capture write this cycle
    logic [DW-1:0] rdata_w [2];

    assign edge_w    = bus.next_out & ~prev_q;
    assign rd_fire_w = full_q[rd_bank_q] & bus.m_ready;
    assign rd_last_w = rd_fire_w && (rd_idx_q == LAST_IDX);

    // A bank emptied by this cycle's final handshake may be claimed at once;
    // the read pointer has moved to the other bank by the first write.
    assign target_free_w = ~full_q[wr_bank_q] |
                           (rd_last_w && (rd_bank_q == wr_bank_q));

    // Register state, edge history and overflow.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            wr_idx_q  <= '0;
            wr_bank_q <= BANK0;
            rd_idx_q  <= '0;
            rd_bank_q <= BANK0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_idx_q  <= rd_idx_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            prev_q    <= bus.next_out;
        end
    end

    // Next-state for the read pointer, capture sequencer, bank flags, overflow.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        ovf_d     = ovf_q;
        drop_w    = 1'b0;
        cap_we_w  = 1'b0;

        // Read side: walk the frame, release the bank after its last word.
        if (rd_fire_w) begin
            if (rd_last_w) begin
                rd_idx_d          = '0;
                rd_bank_d         = other_bank(rd_bank_q);
                full_d[rd_bank_q] = 1'b0;
            end else begin
                rd_idx_d = rd_idx_q + IW'(1);
            end
        end

        // Capture side.
        case (state_q)
            ST_IDLE: begin
                if (edge_w) begin
                    if (target_free_w) begin
                        state_d  = ST_CAPTURE;
                        wr_idx_d = '0;
                    end else begin
                        drop_w = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (edge_w) begin
                    // A fresh frame supersedes the partial one in the same bank.
                    wr_idx_d = '0;
                end else begin
                    cap_we_w = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d           = ST_IDLE;
                        wr_idx_d          = '0;
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = other_bank(wr_bank_q);
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop_w) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong storage
    // ------------------------------------------------------------------
    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        logic we_w;
        assign we_w = cap_we_w & (int'(wr_bank_q) == gb);

        idft_frame_bank #(
            .WORDS (WORDS),
            .DW    (DW)
        ) u_bank (
            .clk_i   (wb_clk_i),
            .we_i    (we_w),
            .waddr_i (wr_idx_q),
            .wdata_i (bus.y_in),
            .raddr_i (rd_idx_q),
            .rdata_o (rdata_w[gb])
        );
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.m_valid  = full_q[rd_bank_q];
    assign bus.m_data   = rdata_w[rd_bank_q];
    assign bus.m_last   = full_q[rd_bank_q] && (rd_idx_q == LAST_IDX);
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == ST_CAPTURE) | (|full_q);

endmodule : idft_stream_out
`default_nettype wire

// File: tb/tb_idft_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_idft_stream_out
// Description : Directed self-checking bench for idft_stream_out. Expected
//               words are queued as frames are driven and compared when the
//               stream hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idft_stream_out;

    localparam int WORDS = 32;
    localparam int DW    = 64;

    logic clk;
    logic rst;

    idft_stream_out_if #(.DW(DW)) bus ();

    idft_stream_out #(
        .WORDS (WORDS),
        .DW    (DW)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW:0]   exp_q [$];   // {last, data}
    logic          have_hold = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge cycle, then WORDS words base+0 .. base+WORDS-1.
    task automatic send_frame(input logic [63:0] base, input bit push, input bit chk_lat);
        bus.next_out = 1'b1;
        bus.y_in     = 64'hDEAD_BEEF_0000_0000;
        tick();
        bus.next_out = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            bus.y_in = base + 64'(i);
            if (push) exp_q.push_back({(i == WORDS - 1), base + 64'(i)});
            if (chk_lat && i == WORDS - 1) check("valid_before_latency", 64'(bus.m_valid), 64'd0);
            tick();
        end
        bus.y_in = '0;
        if (chk_lat) check("valid_at_latency", 64'(bus.m_valid), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    // Stream monitor: scoreboard pops on handshake, stability under stall.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold && bus.m_valid) begin
                check("stall_data", bus.m_data, hold_data);
                check("stall_last", 64'(bus.m_last), 64'(hold_last));
            end
            if (bus.m_valid && bus.m_ready) begin
                check("pop_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_data", bus.m_data, e[DW-1:0]);
                    check("m_last", 64'(bus.m_last), 64'(e[DW]));
                end
                have_hold = 1'b0;
            end else if (bus.m_valid) begin
                have_hold = 1'b1;
                hold_data = bus.m_data;
                hold_last = bus.m_last;
            end else begin
                have_hold = 1'b0;
            end
        end
    end

    initial begin
        int n;
        rst          = 1'b1;
        bus.next_out = 1'b0;
        bus.y_in     = '0;
        bus.m_ready  = 1'b0;
        bus.clr_ovf  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_m_valid",  64'(bus.m_valid),  64'd0);
        check("rst_m_last",   64'(bus.m_last),   64'd0);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        rst = 1'b0;
        tick();

        // Single frame, ready held high, first word at edge+WORDS+1
        bus.m_ready = 1'b1;
        send_frame(64'h1000_0000_0000_0000, 1'b1, 1'b1);
        check("busy_with_frame", 64'(bus.busy), 64'd1);
        drain(200);
        tick();
        check("idle_after_frame", 64'(bus.busy), 64'd0);

        // Two frames stalled, third dropped, then both replayed intact
        bus.m_ready = 1'b0;
        send_frame(64'h2000_0000_0000_0000, 1'b1, 1'b0);
        send_frame(64'h3000_0000_0000_0000, 1'b1, 1'b0);
        check("both_full_busy",  64'(bus.busy),     64'd1);
        check("both_full_valid", 64'(bus.m_valid),  64'd1);
        check("no_ovf_yet",      64'(bus.overflow), 64'd0);
        send_frame(64'h4000_0000_0000_0000, 1'b0, 1'b0);
        check("ovf_after_drop",  64'(bus.overflow), 64'd1);
        bus.m_ready = 1'b1;
        drain(300);
        repeat (2) tick();
        check("drained_valid",   64'(bus.m_valid),  64'd0);
        check("drained_busy",    64'(bus.busy),     64'd0);
        check("ovf_sticky",      64'(bus.overflow), 64'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared",     64'(bus.overflow), 64'd0);

        // Restart: edge at T, second edge at T+10, only the second frame kept
        bus.next_out = 1'b1;
        bus.y_in     = 64'hBAD0_0000_0000_0000;
        tick();
        bus.next_out = 1'b0;
        for (int i = 1; i < 10; i++) begin
            bus.y_in = 64'hBAD0_0000_0000_0000 + 64'(i);
            tick();
        end
        send_frame(64'h5000_0000_0000_0000, 1'b1, 1'b0);
        check("restart_ovf", 64'(bus.overflow), 64'd0);
        drain(200);
        repeat (3) tick();
        check("restart_single_frame", 64'(bus.m_valid), 64'd0);

        // Drop concurrent with clr_ovf: the drop wins
        bus.m_ready = 1'b0;
        send_frame(64'h6000_0000_0000_0000, 1'b1, 1'b0);
        send_frame(64'h7000_0000_0000_0000, 1'b1, 1'b0);
        bus.next_out = 1'b1;
        bus.clr_ovf  = 1'b1;
        tick();
        bus.next_out = 1'b0;
        bus.clr_ovf  = 1'b0;
        check("drop_beats_clear", 64'(bus.overflow), 64'd1);
        tick();
        check("drop_ovf_held",    64'(bus.overflow), 64'd1);
        bus.m_ready = 1'b1;
        drain(300);

        // Ready toggling every cycle: no loss, no duplication, stable stalls
        bus.m_ready = 1'b0;
        send_frame(64'h8000_0000_0000_0000, 1'b1, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            bus.m_ready = ~bus.m_ready;
            tick();
            n++;
        end
        check("toggle_drained", 64'(exp_q.size()), 64'd0);

        // Reset while word 5 is presented
        bus.m_ready = 1'b1;
        repeat (3) tick();
        send_frame(64'h9000_0000_0000_0000, 1'b1, 1'b0);
        n = 0;
        while (exp_q.size() != WORDS - 5 && n < 100) begin
            tick();
            n++;
        end
        check("reached_word5", 64'(exp_q.size()), 64'(WORDS - 5));
        check("word5_on_bus",  bus.m_data, 64'h9000_0000_0000_0005);
        rst         = 1'b1;
        bus.m_ready = 1'b0;
        tick();
        check("rst_mid_valid",    64'(bus.m_valid),  64'd0);
        check("rst_mid_overflow", 64'(bus.overflow), 64'd0);
        check("rst_mid_busy",     64'(bus.busy),     64'd0);
        exp_q.delete();
        rst         = 1'b0;
        bus.m_ready = 1'b1;
        // next_out high in the first cycle out of reset is an edge
        send_frame(64'hA000_0000_0000_0000, 1'b1, 1'b1);
        drain(200);
        repeat (2) tick();
        check("final_idle", 64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_idft_stream_out
`default_nettype wire

// File: doc/idft_stream_out.md
IDFT_STREAM_OUT -- requirements
Module: idft_stream_out

Interface
REQ-001 Parameter WORDS, default 32: 64-bit words per frame; one word per cycle after the start of an output frame.
REQ-002 Parameter DW, default 64: word width, packing {Y3,Y2,Y1,Y0} at 16 bits each.
REQ-003 Port wb_clk_i  input  1  the only clock; all logic on its rising edge.
REQ-004 Port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-005 Port next_out  input  1  frame-start strobe from the IDFT core.
REQ-006 Port y_in  input  DW  IDFT output word, valid on the WORDS cycles after a next_out rising edge.
REQ-007 Port m_valid  output  1  stream word available.
REQ-008 Port m_data  output  DW  stream word.
REQ-009 Port m_last  output  1  high with the final word (index WORDS-1) of a frame.
REQ-010 Port m_ready  input  1  downstream accepts the word when high with m_valid.
REQ-011 Port overflow  output  1  sticky: at least one frame dropped.
REQ-012 Port clr_ovf  input  1  clears overflow.
REQ-013 Port busy  output  1  high while a capture is in progress or either bank is full.

Function
REQ-014 Rising edge = next_out high in cycle T, low in T-1 (registered previous value); a level held high is not a new edge.
REQ-015 On an edge at T with a free bank, capture writes y_in at T+1..T+WORDS into word 0..WORDS-1 of that bank.
REQ-016 Two banks (ping-pong); capture picks bank wr_bank, which toggles once the frame completes.
REQ-017 Bank marked full in the cycle after word WORDS-1 is written; earliest m_valid is T+WORDS+1.
REQ-018 Edge while capturing: capture restarts at word 0 in the same bank; the partial frame is discarded, no overflow.
REQ-019 Edge with both banks full (or target bank full): frame dropped, no writes, overflow set at T+1.
REQ-020 Read side: m_valid = bank rd_bank full; m_data = word rd_idx of that bank; m_last = (rd_idx == WORDS-1).
REQ-021 m_data and m_last hold stable while m_valid high and m_ready low.
REQ-022 On m_valid & m_ready, rd_idx increments; on the last word, rd_idx wraps to 0, the bank is freed, and rd_bank toggles.
REQ-023 A bank freed by a handshake in cycle T is eligible for a capture edge detected in cycle T.
REQ-024 Bank read (m_data) and bank write never target the same bank simultaneously.
REQ-025 clr_ovf clears overflow next cycle; a concurrent drop event wins (overflow stays 1).
REQ-026 Frame order preserved: frames stream in capture order, words in index order 0..WORDS-1.

Reset
REQ-027 Reset clears: both bank-full flags, wr_bank, rd_bank, rd_idx, capture state, edge register, overflow; m_valid=0, m_last=0, busy=0.
REQ-028 Reset mid-capture or mid-stream discards all frames; bank contents need no reset, m_data is don't-care while m_valid=0.
REQ-029 next_out high on the first cycle after reset counts as a rising edge.

Structure
REQ-030 Shared package idft_stream_pkg: WORDS, DW, index width clog2(WORDS), bank-select type.
REQ-031 Single sub-module idft_frame_bank: WORDS x DW storage, one synchronous write port, one combinational read port; instantiated twice.
REQ-032 Capture FSM states IDLE and CAPTURE; index counter 0..WORDS-1; IDLE -> CAPTURE on an accepted edge, CAPTURE -> IDLE after word WORDS-1.

Verification
REQ-033 Edge at T, y_in = 0x1000_0000_0000_0000 + i at T+1+i, m_ready=1 -> m_valid at T+33, words 0..31 in order, m_last on word 31.
REQ-034 Two frames back-to-back, m_ready=0 -> both banks full, busy=1; third edge -> overflow=1, frame dropped; release m_ready -> frames 1,2 intact.
REQ-035 Edge at T, second edge at T+10 -> one frame, containing data from T+11..T+42.
REQ-036 m_ready toggled 1/0 each cycle -> 32 words, none lost or duplicated, m_data stable when stalled.
REQ-037 wb_rst_i asserted during streaming word 5 -> m_valid=0 next cycle, overflow=0, next frame captured into bank 0.
REQ-038 clr_ovf in the same cycle as a drop event -> overflow remains 1.
